// File: rtl/sync_fifo_pkg.sv
// Shared sizing helpers for the single-clock FIFO: storage depth and the
// width of the wrap-bit-extended read/write pointers.
package sync_fifo_pkg;

    function automatic int unsigned fifo_depth(input int unsigned addr_width);
        return 32'd1 << addr_width;
    endfunction

    function automatic int unsigned ptr_width(input int unsigned addr_width);
        return addr_width + 32'd1;
    endfunction

endpackage

// File: rtl/sync_fifo_core_if.sv
// Producer/consumer handshake bundle for sync_fifo_core.
// The overflow/underflow pair exists only when SYNC_FIFO_ERR_FLAGS_EN is defined.
interface sync_fifo_core_if #(
    parameter int unsigned DATA_WIDTH = 32'd8
);
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  full;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  empty;
    logic                  has_data;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wr_en, wr_data, rd_en,
        input  full, rd_data, empty, has_data, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en,
        output full, rd_data, empty, has_data, overflow, underflow
    );
`else
    modport master (
        output wr_en, wr_data, rd_en,
        input  full, rd_data, empty, has_data
    );

    modport slave (
        input  wr_en, wr_data, rd_en,
        output full, rd_data, empty, has_data
    );
`endif
endinterface

// File: rtl/sync_fifo_core_rst_release_sync.sv
// Two-flop reset-release sequencer: in_rst_o asserts asynchronously with rst_n
// and drops on the second rising clk edge after rst_n deasserts.
module rst_release_sync (
    input  logic clk,
    input  logic rst_n,
    output logic in_rst_o,
    output logic in_rst_nxt_o
);
    logic stage1_q;
    logic in_rst_q;

    // Shift a one through the synchroniser once rst_n is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage1_q <= 1'b0;
            in_rst_q <= 1'b1;
        end else begin
            stage1_q <= 1'b1;
            in_rst_q <= ~stage1_q;
        end
    end

    // in_rst_nxt_o lets the flag registers leave reset on the same edge as in_rst.
    assign in_rst_o     = in_rst_q;
    assign in_rst_nxt_o = ~stage1_q;

endmodule

// File: rtl/sync_fifo_core.sv
// Single-clock FIFO, 2**ADDR_WIDTH words, registered read data and flags.
// Optional sticky overflow/underflow outputs are built with SYNC_FIFO_ERR_FLAGS_EN.
module sync_fifo_core
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32'd8,
    parameter int unsigned ADDR_WIDTH = 32'd4,
    parameter int unsigned RESERVE    = 32'd0
) (
    input  logic            clk,
    input  logic            rst_n,
    sync_fifo_core_if.slave fifo_if
);
    localparam int unsigned      DEPTH    = fifo_depth(ADDR_WIDTH);
    localparam int unsigned      PTR_W    = ptr_width(ADDR_WIDTH);
    localparam logic [PTR_W-1:0] FULL_LVL = PTR_W'(DEPTH - RESERVE);

    logic                  in_rst_s;
    logic                  in_rst_nxt_s;
    logic                  wr_acc_s;
    logic                  rd_acc_s;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  has_data_q, has_data_d;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    rst_release_sync u_rst_release_sync (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_rst_o     (in_rst_s),
        .in_rst_nxt_o (in_rst_nxt_s)
    );

    // Accept logic, next pointers and next-state flags.
    always_comb begin
        wr_acc_s = fifo_if.wr_en & ~full_q  & ~in_rst_s;
        rd_acc_s = fifo_if.rd_en & ~empty_q & ~in_rst_s;
        wr_ptr_d = wr_acc_s ? (wr_ptr_q + PTR_W'(1'b1)) : wr_ptr_q;
        rd_ptr_d = rd_acc_s ? (rd_ptr_q + PTR_W'(1'b1)) : rd_ptr_q;
        count_d  = wr_ptr_d - rd_ptr_d;
        if (in_rst_nxt_s) begin
            full_d     = 1'b1;
            empty_d    = 1'b1;
            has_data_d = 1'b0;
        end else begin
            full_d     = (count_d >= FULL_LVL);
            empty_d    = (count_d == {PTR_W{1'b0}});
            has_data_d = (count_d != {PTR_W{1'b0}});
        end
    end

    // Pointers, flags and read data register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            full_q     <= 1'b1;
            empty_q    <= 1'b1;
            has_data_q <= 1'b0;
            rd_data_q  <= {DATA_WIDTH{1'b0}};
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            has_data_q <= has_data_d;
            if (rd_acc_s) begin
                rd_data_q <= mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
            end
        end
    end

    // Storage array; contents are only meaningful between the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= fifo_if.wr_data;
        end
    end

    assign fifo_if.full     = full_q;
    assign fifo_if.empty    = empty_q;
    assign fifo_if.has_data = has_data_q;
    assign fifo_if.rd_data  = rd_data_q;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic overflow_q;
    logic underflow_q;

    // Sticky error flags; requests during the reset-release window are not errors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (fifo_if.wr_en & full_q & ~in_rst_s) begin
                overflow_q <= 1'b1;
            end
            if (fifo_if.rd_en & empty_q & ~in_rst_s) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign fifo_if.overflow  = overflow_q;
    assign fifo_if.underflow = underflow_q;
`else
    // Without error flags, illegal requests are dropped silently by the accept logic.
`endif

endmodule

// File: tb/tb_sync_fifo_core.sv
// Directed scoreboard bench for sync_fifo_core (RESERVE=0 main instance,
// RESERVE=2 secondary instance); error flags checked when SYNC_FIFO_ERR_FLAGS_EN is set.
module tb_sync_fifo_core;
    localparam int DEPTH = 16;

    logic clk;
    logic rst_n;

    sync_fifo_core_if #(.DATA_WIDTH(8)) bus  ();
    sync_fifo_core_if #(.DATA_WIDTH(8)) bus2 ();

    sync_fifo_core #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .RESERVE(0)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .fifo_if (bus)
    );

    sync_fifo_core #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .RESERVE(2)) dut_res (
        .clk     (clk),
        .rst_n   (rst_n),
        .fifo_if (bus2)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] sb [$];
    int         model_cnt;
    logic [7:0] last_rd;
    logic       wr_ok;
    logic       rd_ok;
    logic       ovf_exp;
    logic       udf_exp;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle on the main instance with the model predicting acceptance.
    task automatic cycle(input logic we, input logic [7:0] wd, input logic re);
        logic [7:0] exp_d;
        logic       ovf_n;
        logic       udf_n;
        bus.wr_en   = we;
        bus.wr_data = wd;
        bus.rd_en   = re;
        wr_ok = we && (model_cnt < DEPTH);
        rd_ok = re && (model_cnt > 0);
        ovf_n = ovf_exp | (we && (model_cnt >= DEPTH));
        udf_n = udf_exp | (re && (model_cnt == 0));
        @(posedge clk);
        #1;
        if (rd_ok) begin
            exp_d   = sb.pop_front();
            last_rd = exp_d;
            model_cnt--;
            check("rd_data", 32'(bus.rd_data), 32'(exp_d));
        end else begin
            check("rd_data_hold", 32'(bus.rd_data), 32'(last_rd));
        end
        if (wr_ok) begin
            sb.push_back(wd);
            model_cnt++;
        end
        ovf_exp = ovf_n;
        udf_exp = udf_n;
        check("full",     32'(bus.full),     32'(model_cnt >= DEPTH));
        check("empty",    32'(bus.empty),    32'(model_cnt == 0));
        check("has_data", 32'(bus.has_data), 32'(model_cnt != 0));
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        check("overflow",  32'(bus.overflow),  32'(ovf_exp));
        check("underflow", 32'(bus.underflow), 32'(udf_exp));
`endif
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
    endtask

    // Hold reset for n cycles with requests active, then check the release sequence.
    task automatic do_reset(input int n);
        rst_n       = 1'b0;
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'hAA;
        bus.rd_en   = 1'b1;
        #1;
        check("rst_full",     32'(bus.full),     32'd1);
        check("rst_empty",    32'(bus.empty),    32'd1);
        check("rst_has_data", 32'(bus.has_data), 32'd0);
        check("rst_rd_data",  32'(bus.rd_data),  32'd0);
        repeat (n) begin
            @(posedge clk);
            #1;
            check("rst_hold_full",  32'(bus.full),  32'd1);
            check("rst_hold_empty", 32'(bus.empty), 32'd1);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel1_full",  32'(bus.full),  32'd1);
        check("rel1_empty", 32'(bus.empty), 32'd1);
        @(posedge clk);
        #1;
        check("rel2_full",     32'(bus.full),     32'd0);
        check("rel2_empty",    32'(bus.empty),    32'd1);
        check("rel2_has_data", 32'(bus.has_data), 32'd0);
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        sb.delete();
        model_cnt = 0;
        last_rd   = 8'd0;
        ovf_exp   = 1'b0;
        udf_exp   = 1'b0;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        check("rst_overflow",  32'(bus.overflow),  32'd0);
        check("rst_underflow", 32'(bus.underflow), 32'd0);
`endif
        cycle(1'b0, 8'd0, 1'b0);
    endtask

    initial begin
        int wr_next;
        int rd_n;
        int cyc;
        int n2;
        logic we;
        logic re;

        rst_n        = 1'b1;
        bus.wr_en    = 1'b0;
        bus.wr_data  = 8'd0;
        bus.rd_en    = 1'b0;
        bus2.wr_en   = 1'b0;
        bus2.wr_data = 8'd0;
        bus2.rd_en   = 1'b0;
        model_cnt    = 0;
        last_rd      = 8'd0;
        ovf_exp      = 1'b0;
        udf_exp      = 1'b0;
        #2;
        do_reset(4);

        // Fill to full with gaps, attempt an overflow, drain, attempt an underflow.
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, 8'(i), 1'b0);
            cycle(1'b0, 8'd0, 1'b0);
        end
        cycle(1'b1, 8'hEE, 1'b0);
        cycle(1'b1, 8'hEF, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, 8'd0, 1'b1);
            cycle(1'b0, 8'd0, 1'b0);
        end
        cycle(1'b0, 8'd0, 1'b1);
        cycle(1'b0, 8'd0, 1'b0);

        // Steady stream: prefill 8, then concurrent random-rate writer and reader.
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 8'(i), 1'b0);
        end
        wr_next = 8;
        rd_n    = 0;
        cyc     = 0;
        while (rd_n < 200 && cyc < 3000) begin
            we = (wr_next < 200) && ($urandom_range(0, 3) != 0);
            re = ($urandom_range(0, 4) != 0);
            cycle(we, 8'(wr_next), re);
            if (wr_ok) wr_next++;
            if (rd_ok) rd_n++;
            cyc++;
        end
        check("stream_reads", 32'(rd_n), 32'd200);

        // Bursts of 14 writes then 14 reads, crossing the pointer wrap.
        for (int b = 0; b < 5; b++) begin
            for (int i = 0; i < 14; i++) cycle(1'b1, 8'(b * 14 + i), 1'b0);
            for (int i = 0; i < 14; i++) cycle(1'b0, 8'd0, 1'b1);
        end

        // Gapped writer against gapped reader.
        for (int i = 0; i < 50; i++) begin
            cycle(1'b1, 8'(i), 1'b0);
            cycle(1'b0, 8'd0, 1'b1);
        end

        // Reset mid-operation discards contents.
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h50 + i), 1'b0);
        do_reset(20);
        cycle(1'b0, 8'd0, 1'b1);
        cycle(1'b1, 8'h77, 1'b0);
        cycle(1'b0, 8'd0, 1'b1);

        // RESERVE=2 instance: full at 14 words, extra writes dropped.
        for (int i = 0; i < DEPTH; i++) begin
            bus2.wr_en   = 1'b1;
            bus2.wr_data = 8'(8'h30 + i);
            @(posedge clk);
            #1;
            n2 = (i + 1 < 14) ? (i + 1) : 14;
            check("res_full", 32'(bus2.full), 32'(n2 >= 14));
        end
        bus2.wr_en = 1'b0;
        check("res_has_data", 32'(bus2.has_data), 32'd1);
        for (int i = 0; i < 14; i++) begin
            bus2.rd_en = 1'b1;
            @(posedge clk);
            #1;
            check("res_rd_data", 32'(bus2.rd_data), 32'(8'h30 + i));
        end
        check("res_empty", 32'(bus2.empty), 32'd1);
        @(posedge clk);
        #1;
        bus2.rd_en = 1'b0;
        check("res_rd_hold", 32'(bus2.rd_data), 32'(8'h3D));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_fifo_core.md
Name: sync_fifo_core

Overview:
- Single-clock FIFO with the same write/read handshake and flag semantics as the dual-clock FIFO family in the codebase.
- Stores 2**ADDR_WIDTH words.
- Registered read data, programmable full reserve, internal reset-release sequencing.
- Used as a streaming buffer between producer and consumer logic in the same clock domain.

Parameters:
- DATA_WIDTH, 8, width of each stored word.
- ADDR_WIDTH, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH (16).
- RESERVE, 0, number of free slots still remaining when full asserts; legal range 0..DEPTH-1.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  write request; one word per cycle while high and full is low.
- wr_data  in  DATA_WIDTH  write word, captured with wr_en.
- full  out  1  no further writes accepted.
- rd_en  in  1  read request; one word per cycle while high and empty is low.
- rd_data  out  DATA_WIDTH  registered read word.
- empty  out  1  FIFO holds no words.
- has_data  out  1  FIFO holds at least one word.

Behaviour:
- Storage and pointers:
  - Storage is DEPTH x DATA_WIDTH.
  - wr_ptr and rd_ptr are ADDR_WIDTH+1 bits: the MSB is a wrap bit, the low bits address storage.
  - count = wr_ptr - rd_ptr, modulo 2**(ADDR_WIDTH+1), range 0..DEPTH.
- Reset:
  - rst_n low asynchronously clears pointers and rd_data, and holds the internal flag in_rst high.
  - While in_rst is high: full=1, empty=1, has_data=0, rd_data=0.
- Reset release:
  - On rst_n rising, in_rst deasserts after 2 clk edges via a 2-flop synchroniser.
  - wr_en and rd_en are ignored while in_rst is high.
- Write:
  - On clk rising with wr_en=1 and full=0: mem[wr_ptr]<=wr_data and wr_ptr increments.
  - wr_en while full is dropped; no pointer change and no data corruption.
- Read:
  - On clk rising with rd_en=1 and empty=0: rd_data<=mem[rd_ptr] and rd_ptr increments.
  - rd_data is valid from the cycle after the accepting edge and holds until the next accepted read.
  - rd_en while empty is ignored and rd_data holds.
- Flags:
  - Flags are registered, computed from the next-state count, and update on the same edge as the pointer change.
  - full = (count >= DEPTH-RESERVE). With RESERVE=0, exactly DEPTH writes set full.
  - empty = (count == 0).
  - has_data = ~empty when not in reset.
- Simultaneous operation: wr and rd accepted on the same edge leave count unchanged; when count==0 only the write happens.
- Wrap-around: pointers wrap naturally modulo 2**(ADDR_WIDTH+1); order is preserved indefinitely.
- Reset mid-operation: all contents are discarded immediately; after release the FIFO is empty.

Optional Feature:
- Macro: SYNC_FIFO_ERR_FLAGS_EN.
- Defined:
  - Adds outputs overflow and underflow, 1 bit each.
  - overflow sets on wr_en while full; underflow sets on rd_en while empty.
  - Both are sticky until reset.
- Undefined:
  - Ports absent; illegal requests are silently ignored as described above.

Decomposition:
- Package sync_fifo_pkg: no typedefs needed beyond a localparam function for DEPTH and the pointer width (ADDR_WIDTH+1).
- One sub-module, rst_release_sync: 2-flop active-low reset synchroniser producing in_rst.
- Storage, pointers and flags stay in the top module.

Test Plan:
- Fill-to-full:
  - Stimulus: after reset release, write 0,1,2,... singly with gaps.
  - Response: full asserts after exactly 16 writes.
  - Then read until empty: get 0..15 in order, read count 16, empty=1, has_data=0.
- Steady stream:
  - Stimulus: prefill 8 words, then concurrently write 8..199 (stall while full) and read 200 words (stall while empty).
  - Response: data 0..199 in order, no loss or duplication.
- Bursts:
  - Stimulus: 5 bursts of 14 writes, each followed by 14 reads.
  - Response: read values 0..69 sequential across pointer wrap.
- Gaps:
  - Stimulus: 50 writes with a 1-cycle idle between each, against a reader with 1-cycle read gaps.
  - Response: values 0..49 in order.
- Reset and flags:
  - Stimulus: hold rst_n low for 20 cycles.
  - Response: full=1, empty=1 until 2 edges after release; wr_en during that window does not change count.
  - Stimulus: RESERVE=2.
  - Response: full asserts at 14 words.
- Illegal access:
  - Stimulus: write when full, read when empty.
  - Response: contents and rd_data unchanged.
  - With SYNC_FIFO_ERR_FLAGS_EN: overflow and underflow set and stay set until reset.
